// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the codec configuration scheduler:
// FSM state encoding, the 11-word boot table and the default device address.
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOOT,
        S_ARB,
        S_SEND,
        S_WAIT
    } state_t;

    localparam int         BOOT_COUNT       = 11;
    localparam logic [7:0] DEV_ADDR_DEFAULT = 8'h34;

    // Boot payloads are {7-bit register address, 9-bit data}.
    localparam logic [15:0] BOOT_RESET     = 16'h1E00;
    localparam logic [15:0] BOOT_LLINE_IN  = 16'h0017;
    localparam logic [15:0] BOOT_RLINE_IN  = 16'h0217;
    localparam logic [15:0] BOOT_LHP_OUT   = 16'h0479;
    localparam logic [15:0] BOOT_RHP_OUT   = 16'h0679;
    localparam logic [15:0] BOOT_ANALOGUE  = 16'h0812;
    localparam logic [15:0] BOOT_DIGITAL   = 16'h0A00;
    localparam logic [15:0] BOOT_POWER     = 16'h0C00;
    localparam logic [15:0] BOOT_INTERFACE = 16'h0E0A;
    localparam logic [15:0] BOOT_SAMPLING  = 16'h1000;
    localparam logic [15:0] BOOT_ACTIVE    = 16'h1201;

    function automatic logic [15:0] boot_payload(input logic [3:0] idx);
        logic [15:0] p;
        case (idx)
            4'd0:    p = BOOT_RESET;
            4'd1:    p = BOOT_LLINE_IN;
            4'd2:    p = BOOT_RLINE_IN;
            4'd3:    p = BOOT_LHP_OUT;
            4'd4:    p = BOOT_RHP_OUT;
            4'd5:    p = BOOT_ANALOGUE;
            4'd6:    p = BOOT_DIGITAL;
            4'd7:    p = BOOT_POWER;
            4'd8:    p = BOOT_INTERFACE;
            4'd9:    p = BOOT_SAMPLING;
            4'd10:   p = BOOT_ACTIVE;
            default: p = 16'h0000;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/codec_cfg_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index strictly above ptr,
// wrapping around; combinational, one-hot grant.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               any_grant
);

    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!any_grant && req[(int'(ptr) + i) % NUM_REQ]) begin
                grant[(int'(ptr) + i) % NUM_REQ] = 1'b1;
                any_grant                        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/codec_cfg_scheduler.sv
// Codec register-write scheduler: plays the boot table once, then round-robins
// runtime requesters onto a single I2C writer. Define CODEC_CFG_RETRY_EN for NACK resends.
//
// Writer handshake: a word transfers on the cycle o_wr_valid && i_wr_ready; o_wr_word is
// held stable while o_wr_valid is high. Completion is the i_wr_done pulse, with i_wr_nack
// meaningful only in that cycle; done pulses outside the wait state are ignored.
module codec_cfg_scheduler
    import codec_cfg_pkg::*;
#(
    parameter int         NUM_REQ   = 2,
    parameter int         MAX_RETRY = 3,
    parameter logic [7:0] DEV_ADDR  = DEV_ADDR_DEFAULT
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ-1:0][15:0] i_req_word,
    output logic [NUM_REQ-1:0]       o_ack,
    output logic                     o_wr_valid,
    output logic [23:0]              o_wr_word,
    input  logic                     i_wr_ready,
    input  logic                     i_wr_done,
    input  logic                     i_wr_nack,
    output logic                     o_boot_done,
    output logic                     o_busy,
    output logic                     o_error,
    output state_t                   o_dbg_state
);

    localparam int         PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] BOOT_LAST = 4'(BOOT_COUNT - 1);

    state_t               state, state_next;
    logic [3:0]           boot_idx;
    logic [PTR_W-1:0]     last_grant;
    logic [PTR_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]   ack_q;
    logic [NUM_REQ-1:0]   arb_req;
    logic [NUM_REQ-1:0]   arb_grant;
    logic                 any_grant;
    logic [23:0]          wr_word;
    logic                 boot_done;
    logic                 error_q;
    logic                 retry_now;

`ifdef CODEC_CFG_RETRY_EN
    localparam int RTRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RTRY_W-1:0] retry;
    assign retry_now = i_wr_nack && (retry < RTRY_W'(MAX_RETRY));
`else
    assign retry_now = 1'b0;
`endif

    // The retiring requester still holds i_req during its ack cycle; mask it so a
    // lone requester is not granted twice for one request.
    assign arb_req = i_req & ~ack_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req       (arb_req),
        .ptr       (last_grant),
        .grant     (arb_grant),
        .any_grant (any_grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) grant_idx = PTR_W'(i);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        o_wr_valid = 1'b0;
        o_busy     = 1'b1;
        case (state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) state_next = S_BOOT;
            end
            S_BOOT: state_next = S_SEND;
            S_ARB: begin
                o_busy = |i_req;
                if (any_grant) state_next = S_SEND;
            end
            S_SEND: begin
                o_wr_valid = 1'b1;
                if (i_wr_ready) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_wr_done) begin
                    if (retry_now)                          state_next = S_SEND;
                    else if (boot_done)                     state_next = S_ARB;
                    else if (boot_idx == BOOT_LAST)         state_next = S_ARB;
                    else                                    state_next = S_BOOT;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            boot_idx   <= '0;
            last_grant <= PTR_W'(NUM_REQ - 1);
            ack_q      <= '0;
            wr_word    <= '0;
            boot_done  <= 1'b0;
            error_q    <= 1'b0;
`ifdef CODEC_CFG_RETRY_EN
            retry      <= '0;
`endif
        end else begin
            ack_q <= '0;
            case (state)
                S_BOOT: begin
                    wr_word <= {DEV_ADDR, boot_payload(boot_idx)};
`ifdef CODEC_CFG_RETRY_EN
                    retry   <= '0;
`endif
                end
                S_ARB: begin
                    if (any_grant) begin
                        wr_word    <= {DEV_ADDR, i_req_word[grant_idx]};
                        last_grant <= grant_idx;
`ifdef CODEC_CFG_RETRY_EN
                        retry      <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (i_wr_done) begin
                        if (retry_now) begin
`ifdef CODEC_CFG_RETRY_EN
                            retry <= retry + 1'b1;
`endif
                        end else begin
                            if (i_wr_nack) error_q <= 1'b1;
                            if (!boot_done) begin
                                if (boot_idx == BOOT_LAST) boot_done <= 1'b1;
                                else                       boot_idx  <= boot_idx + 4'd1;
                            end else begin
                                ack_q <= NUM_REQ'(1) << last_grant;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ack       = ack_q;
    assign o_wr_word   = wr_word;
    assign o_boot_done = boot_done;
    assign o_error     = error_q;
    assign o_dbg_state = state;

endmodule

// File: tb/tb_codec_cfg_scheduler.sv
// Directed bench for codec_cfg_scheduler: boot order, boot priority, round-robin,
// word latching, start filtering, mid-transfer reset and NACK handling.
module tb_codec_cfg_scheduler;
    import codec_cfg_pkg::*;

    localparam int NUM_REQ   = 2;
    localparam int MAX_RETRY = 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0][15:0] req_word;
    logic [NUM_REQ-1:0]       ack;
    logic                     wr_valid;
    logic [23:0]              wr_word;
    logic                     wr_ready;
    logic                     wr_done;
    logic                     wr_nack;
    logic                     boot_done;
    logic                     busy;
    logic                     error;
    state_t                   dbg_state;

    int total = 0;
    int bad   = 0;
    logic [23:0] boot_exp [11];

    codec_cfg_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .MAX_RETRY (MAX_RETRY),
        .DEV_ADDR  (8'h34)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_req       (req),
        .i_req_word  (req_word),
        .o_ack       (ack),
        .o_wr_valid  (wr_valid),
        .o_wr_word   (wr_word),
        .i_wr_ready  (wr_ready),
        .i_wr_done   (wr_done),
        .i_wr_nack   (wr_nack),
        .o_boot_done (boot_done),
        .o_busy      (busy),
        .o_error     (error),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        wr_ready = 1'b0;
        wr_done  = 1'b0;
        wr_nack  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // drivers
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for an offered word, accepts it with a one-cycle ready, then pulses done
    // (with the given nack). Returns what was seen, including ack/error/boot_done
    // sampled in the cycle after done.
    task automatic serve_word(input logic nack, output logic found, output logic [23:0] word,
                              output logic [NUM_REQ-1:0] ack_seen, output logic err_seen,
                              output logic bdone_seen);
        int t = 0;
        while (!wr_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        found      = wr_valid;
        word       = wr_word;
        ack_seen   = '0;
        err_seen   = 1'b0;
        bdone_seen = 1'b0;
        if (!found) return;
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        wr_done  = 1'b1;
        wr_nack  = nack;
        @(negedge clk);
        wr_done    = 1'b0;
        wr_nack    = 1'b0;
        ack_seen   = ack;
        err_seen   = error;
        bdone_seen = boot_done;
    endtask

    task automatic test_reset();
        req      = 2'b11;
        req_word = '0;
        do_reset();
        total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", wr_valid); end
        total++; if (wr_word !== 24'h0) begin bad++; $display("FAIL reset_word: got %h want 000000", wr_word); end
        total++; if (ack !== 2'b00) begin bad++; $display("FAIL reset_ack: got %b want 00", ack); end
        total++; if (boot_done !== 1'b0) begin bad++; $display("FAIL reset_boot_done: got %b want 0", boot_done); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        repeat (5) @(negedge clk);
        total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL idle_ignores_req: got valid %b want 0", wr_valid); end
        req = 2'b00;
    endtask

    task automatic test_boot();
        logic f, e, bd;
        logic [23:0] w;
        logic [NUM_REQ-1:0] a;
        req         = 2'b10;
        req_word[1] = 16'hA5C3;
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL boot_busy: got %b want 1", busy); end
        for (int k = 0; k < 11; k++) begin
            serve_word(1'b0, f, w, a, e, bd);
            total++; if (f !== 1'b1) begin bad++; $display("FAIL boot_offer_%0d: no word offered", k); end
            total++; if (w !== boot_exp[k]) begin bad++; $display("FAIL boot_word_%0d: got %h want %h", k, w, boot_exp[k]); end
            total++; if (a !== 2'b00) begin bad++; $display("FAIL boot_ack_%0d: got %b want 00", k, a); end
            total++; if (bd !== (k == 10)) begin bad++; $display("FAIL boot_done_%0d: got %b want %b", k, bd, k == 10); end
        end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL boot_error: got %b want 0", error); end
        serve_word(1'b0, f, w, a, e, bd);
        req = 2'b00;
        total++; if (w !== 24'h34A5C3) begin bad++; $display("FAIL boot_prio_word: got %h want 34a5c3", w); end
        total++; if (a !== 2'b10) begin bad++; $display("FAIL boot_prio_ack: got %b want 10", a); end
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arb_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        logic f, e, bd;
        logic [23:0] w;
        logic [NUM_REQ-1:0] a;
        logic [23:0] exp_w [4] = '{24'h341111, 24'h342222, 24'h341111, 24'h342222};
        logic [NUM_REQ-1:0] exp_a [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        req_word[0] = 16'h1111;
        req_word[1] = 16'h2222;
        req         = 2'b11;
        for (int k = 0; k < 4; k++) begin
            serve_word(1'b0, f, w, a, e, bd);
            total++; if (w !== exp_w[k]) begin bad++; $display("FAIL rr_word_%0d: got %h want %h", k, w, exp_w[k]); end
            total++; if (a !== exp_a[k]) begin bad++; $display("FAIL rr_ack_%0d: got %b want %b", k, a, exp_a[k]); end
        end
        req = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latch();
        logic f, e, bd;
        logic [23:0] w;
        logic [NUM_REQ-1:0] a;
        int t = 0;
        req_word[0] = 16'h3C3C;
        req         = 2'b01;
        while (!wr_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        total++; if (wr_valid !== 1'b1) begin bad++; $display("FAIL latch_offer: got valid %b want 1", wr_valid); end
        req_word[0] = 16'hFFFF;
        repeat (2) @(negedge clk);
        total++; if (wr_word !== 24'h343C3C) begin bad++; $display("FAIL latch_word: got %h want 343c3c", wr_word); end
        serve_word(1'b0, f, w, a, e, bd);
        req = 2'b00;
        total++; if (a !== 2'b01) begin bad++; $display("FAIL latch_ack: got %b want 01", a); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start_ignored();
        pulse_start();
        repeat (5) @(negedge clk);
        total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL restart_valid: got %b want 0", wr_valid); end
        total++; if (boot_done !== 1'b1) begin bad++; $display("FAIL restart_boot_done: got %b want 1", boot_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL restart_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic f, e, bd;
        logic [23:0] w;
        logic [NUM_REQ-1:0] a;
        int t = 0;
        do_reset();
        pulse_start();
        for (int k = 0; k < 5; k++) serve_word(1'b0, f, w, a, e, bd);
        while (!wr_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        total++; if (wr_word !== boot_exp[5]) begin bad++; $display("FAIL mid_word5: got %h want %h", wr_word, boot_exp[5]); end
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        rst_n    = 1'b0;
        #1;
        total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", wr_valid); end
        total++; if (wr_word !== 24'h0) begin bad++; $display("FAIL mid_word: got %h want 000000", wr_word); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        total++; if ({ack, boot_done, error} !== 4'b0000) begin bad++; $display("FAIL mid_flags: got %b want 0000", {ack, boot_done, error}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        serve_word(1'b0, f, w, a, e, bd);
        total++; if (w !== boot_exp[0]) begin bad++; $display("FAIL mid_restart_word: got %h want %h", w, boot_exp[0]); end
    endtask

    task automatic test_nack();
        logic f, e, bd;
        logic [23:0] w;
        logic [NUM_REQ-1:0] a;
`ifdef CODEC_CFG_RETRY_EN
        do_reset();
        pulse_start();
        for (int k = 0; k < 3; k++) serve_word(1'b0, f, w, a, e, bd);
        for (int k = 0; k < 3; k++) begin
            serve_word(k < 2, f, w, a, e, bd);
            total++; if (w !== boot_exp[3]) begin bad++; $display("FAIL retry_word_%0d: got %h want %h", k, w, boot_exp[3]); end
            total++; if (e !== 1'b0) begin bad++; $display("FAIL retry_error_%0d: got %b want 0", k, e); end
        end
        serve_word(1'b0, f, w, a, e, bd);
        total++; if (w !== boot_exp[4]) begin bad++; $display("FAIL retry_next: got %h want %h", w, boot_exp[4]); end
        do_reset();
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            serve_word(1'b1, f, w, a, e, bd);
            total++; if (w !== boot_exp[0]) begin bad++; $display("FAIL exhaust_word_%0d: got %h want %h", k, w, boot_exp[0]); end
            total++; if (e !== (k == 3)) begin bad++; $display("FAIL exhaust_error_%0d: got %b want %b", k, e, k == 3); end
        end
        serve_word(1'b0, f, w, a, e, bd);
        total++; if (w !== boot_exp[1]) begin bad++; $display("FAIL exhaust_next: got %h want %h", w, boot_exp[1]); end
`else
        do_reset();
        pulse_start();
        serve_word(1'b1, f, w, a, e, bd);
        total++; if (w !== boot_exp[0]) begin bad++; $display("FAIL nack_word: got %h want %h", w, boot_exp[0]); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL nack_error: got %b want 1", e); end
        serve_word(1'b0, f, w, a, e, bd);
        total++; if (w !== boot_exp[1]) begin bad++; $display("FAIL nack_next: got %h want %h", w, boot_exp[1]); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL nack_sticky: got %b want 1", e); end
`endif
    endtask

    initial begin
        boot_exp = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679, 24'h340812,
                     24'h340A00, 24'h340C00, 24'h340E0A, 24'h341000, 24'h341201};
        rst_n    = 1'b0;
        start    = 1'b0;
        req      = '0;
        req_word = '0;
        wr_ready = 1'b0;
        wr_done  = 1'b0;
        wr_nack  = 1'b0;
        test_reset();
        test_boot();
        test_round_robin();
        test_latch();
        test_start_ignored();
        test_reset_mid();
        test_nack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/codec_cfg_scheduler.md
CODEC_CFG_SCHEDULER -- requirements
Module: codec_cfg_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 2: number of runtime register-write requesters.
REQ-002 Parameter MAX_RETRY, default 3: resends allowed per word after NACK.
REQ-003 Parameter DEV_ADDR, default 8'h34: codec I2C write address, the first byte of every 24-bit word.
REQ-004 i_clk  input  1  system clock; all state updates on rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_start  input  1  single-cycle pulse that launches the boot sequence.
REQ-007 i_req  input  NUM_REQ  per-requester write request; held high until its o_ack.
REQ-008 i_req_word  input  NUM_REQ x 16  per-requester payload: {7-bit reg addr, 9-bit data}.
REQ-009 o_ack  output  NUM_REQ  one-cycle one-hot pulse when that requester's word retires.
REQ-010 o_wr_valid  output  1  word offered to the downstream I2C writer.
REQ-011 o_wr_word  output  24  {DEV_ADDR, reg addr, data}, MSB first on the wire.
REQ-012 i_wr_ready  input  1  writer accepts o_wr_word when high with o_wr_valid.
REQ-013 i_wr_done  input  1  one-cycle pulse: writer finished the word, STOP sent.
REQ-014 i_wr_nack  input  1  qualified by i_wr_done; high = any of the 3 ACK slots NACKed.
REQ-015 o_boot_done  output  1  high, sticky, once all boot words have retired.
REQ-016 o_busy  output  1  high in every state except S_IDLE and S_ARB with no request.
REQ-017 o_error  output  1  sticky: a word retired with NACK after its final attempt.

Function
REQ-018 States: S_IDLE, S_BOOT, S_ARB, S_SEND, S_WAIT.
REQ-019 S_IDLE -> S_BOOT on i_start; i_req ignored while in S_IDLE.
REQ-020 S_BOOT loads boot word at index boot_idx (0..10: reset, L/R line in, L/R headphone, analogue path, digital path, power, interface format, sampling, active) and goes to S_SEND next cycle.
REQ-021 S_SEND drives o_wr_valid=1 with o_wr_word stable until the cycle i_wr_ready=1, then -> S_WAIT.
REQ-022 S_WAIT holds o_wr_valid=0 until i_wr_done; i_wr_ready is ignored there.
REQ-023 Success (i_wr_done & !i_wr_nack): boot phase increments boot_idx -> S_BOOT; after index 10 sets o_boot_done -> S_ARB; runtime phase pulses o_ack[grant] -> S_ARB.
REQ-024 S_ARB round-robin: grant the lowest i_req index strictly above the last grant, wrapping; latch i_req_word[grant] into o_wr_word -> S_SEND in the same cycle the grant is taken.
REQ-025 Requests changing after grant do not affect the latched word.
REQ-026 i_start while busy or after o_boot_done is ignored; boot runs once per reset.
REQ-027 o_ack is asserted exactly one cycle after the retiring i_wr_done; retry counter clears per word.
REQ-028 i_wr_done seen outside S_WAIT is ignored.
REQ-029 Boot phase has priority: runtime requests never granted before o_boot_done.

Reset
REQ-030 On i_rst_n low: state S_IDLE, boot_idx 0, retry 0, RR pointer NUM_REQ-1 (so requester 0 wins first), o_ack 0, o_wr_valid 0, o_wr_word 0, o_boot_done 0, o_busy 0, o_error 0.
REQ-031 Reset mid-transfer aborts immediately; o_wr_valid drops asynchronously; downstream writer is reset by the same i_rst_n.

Configuration
REQ-032 Macro CODEC_CFG_RETRY_EN defined: on NACK with retry < MAX_RETRY, increment retry and return to S_SEND with the same word; on the final NACK, set o_error and retire (ack/advance) as success.
REQ-033 Macro undefined: no retry counter; any NACK sets o_error and the word retires immediately.

Structure
REQ-034 Package codec_cfg_pkg holds the state enum, boot word count (11), the 11 16-bit boot payload constants and DEV_ADDR default.
REQ-035 Sub-module rr_arbiter (NUM_REQ requests, pointer, one-hot grant, any_grant) is instantiated once; the FSM lives in codec_cfg_scheduler.

Verification
REQ-036 Pulse i_start, writer always ACKs with 1-cycle ready -> 11 words in order, first 24'h341E00, last 24'h341201, o_boot_done after 11th done.
REQ-037 After boot, i_req=2'b11 held -> grants 0,1,0,1 alternating, o_ack one-hot each retire.
REQ-038 RETRY_EN, MAX_RETRY=3, word 3 NACKed 2 times -> same word offered 3 times, o_error stays 0, boot continues.
REQ-039 RETRY_EN, every attempt NACKed -> 4 offers of word 0 then o_error=1, boot_idx advances; without macro -> 1 offer, o_error=1.
REQ-040 i_req[1]=1 during boot -> no grant until o_boot_done; then o_wr_word = {8'h34, i_req_word[1]}.
REQ-041 Assert i_rst_n=0 in S_WAIT of word 5 -> all outputs reset values; new i_start restarts at word 0.
